// File: rtl/axi_ddr_slave_mem.sv
// axi_ddr_slave_mem: AXI4 slave backed by a single-port 2^MEM_AW x 32 memory, one transaction at a time
module axi_ddr_slave_mem #(
  parameter int MEM_AW = 14,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AXI_DDR_awaddr,
  input  logic [7:0]  AXI_DDR_awlen,
  input  logic [2:0]  AXI_DDR_awsize,
  input  logic [1:0]  AXI_DDR_awburst,
  input  logic [3:0]  AXI_DDR_awid,
  input  logic        AXI_DDR_awvalid,
  output logic        AXI_DDR_awready,
  input  logic [2:0]  AXI_DDR_awprot,
  input  logic [3:0]  AXI_DDR_awregion,
  input  logic [3:0]  AXI_DDR_awcache,
  input  logic [3:0]  AXI_DDR_awqos,
  input  logic        AXI_DDR_awlock,
  input  logic        AXI_DDR_awuser,
  input  logic [31:0] AXI_DDR_araddr,
  input  logic [7:0]  AXI_DDR_arlen,
  input  logic [2:0]  AXI_DDR_arsize,
  input  logic [1:0]  AXI_DDR_arburst,
  input  logic [3:0]  AXI_DDR_arid,
  input  logic        AXI_DDR_arvalid,
  output logic        AXI_DDR_arready,
  input  logic [2:0]  AXI_DDR_arprot,
  input  logic [3:0]  AXI_DDR_arregion,
  input  logic [3:0]  AXI_DDR_arcache,
  input  logic [3:0]  AXI_DDR_arqos,
  input  logic        AXI_DDR_arlock,
  input  logic        AXI_DDR_aruser,
  input  logic [31:0] AXI_DDR_wdata,
  input  logic [3:0]  AXI_DDR_wstrb,
  input  logic        AXI_DDR_wlast,
  input  logic [3:0]  AXI_DDR_wuser,
  input  logic        AXI_DDR_wvalid,
  output logic        AXI_DDR_wready,
  output logic [31:0] AXI_DDR_rdata,
  output logic [1:0]  AXI_DDR_rresp,
  output logic        AXI_DDR_rlast,
  output logic [3:0]  AXI_DDR_rid,
  output logic        AXI_DDR_rvalid,
  input  logic        AXI_DDR_rready,
  output logic        AXI_DDR_ruser,
  output logic [1:0]  AXI_DDR_bresp,
  output logic [3:0]  AXI_DDR_bid,
  output logic        AXI_DDR_bvalid,
  input  logic        AXI_DDR_bready,
  output logic        AXI_DDR_buser
);
  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
  state_t state;
  logic [31:0] mem [2**MEM_AW];
  logic [31:0] a_addr;
  logic [7:0] a_len, cnt;
  logic [3:0] a_id;
  logic a_bad, a_fixed, over, dec, rd_last;
  logic win, aw_go, ar_go, w_go, we;
  logic [2:0] sz;
  logic [1:0] bu;
  logic [MEM_AW-1:0] idx;
  logic unused;
  assign unused = ^{AXI_DDR_awprot, AXI_DDR_awregion, AXI_DDR_awcache, AXI_DDR_awqos, AXI_DDR_awlock,
                    AXI_DDR_awuser, AXI_DDR_arprot, AXI_DDR_arregion, AXI_DDR_arcache, AXI_DDR_arqos,
                    AXI_DDR_arlock, AXI_DDR_aruser, AXI_DDR_wuser};
  assign win = a_addr[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2];
  assign idx = a_addr[MEM_AW+1:2];
  // rd_last set means the read channel was served last, so a tie goes to write
  assign aw_go = !rst && state == IDLE && AXI_DDR_awvalid && (rd_last || !AXI_DDR_arvalid);
  assign ar_go = !rst && state == IDLE && AXI_DDR_arvalid && (!rd_last || !AXI_DDR_awvalid);
  assign AXI_DDR_awready = aw_go;
  assign AXI_DDR_arready = ar_go;
  assign AXI_DDR_wready = state == WDATA;
  assign AXI_DDR_ruser = 1'b0;
  assign AXI_DDR_buser = 1'b0;
  assign w_go = AXI_DDR_wready && AXI_DDR_wvalid;
  assign we = !rst && w_go && !a_bad && !over && win;
  assign sz = aw_go ? AXI_DDR_awsize : AXI_DDR_arsize;
  assign bu = aw_go ? AXI_DDR_awburst : AXI_DDR_arburst;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && AXI_DDR_wstrb[i]) mem[idx][8*i +: 8] <= AXI_DDR_wdata[8*i +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_last <= 1'b1;
      a_addr <= '0;
      a_len <= '0;
      a_id <= '0;
      a_bad <= 1'b0;
      a_fixed <= 1'b0;
      cnt <= '0;
      over <= 1'b0;
      dec <= 1'b0;
      AXI_DDR_bvalid <= 1'b0;
      AXI_DDR_bresp <= '0;
      AXI_DDR_bid <= '0;
      AXI_DDR_rvalid <= 1'b0;
      AXI_DDR_rdata <= '0;
      AXI_DDR_rresp <= '0;
      AXI_DDR_rlast <= 1'b0;
      AXI_DDR_rid <= '0;
    end else begin
      case (state)
        IDLE: if (aw_go || ar_go) begin
          a_addr <= aw_go ? AXI_DDR_awaddr : AXI_DDR_araddr;
          a_len <= aw_go ? AXI_DDR_awlen : AXI_DDR_arlen;
          a_id <= aw_go ? AXI_DDR_awid : AXI_DDR_arid;
          a_bad <= sz != 3'd2 || bu[1];
          a_fixed <= bu == 2'b00;
          cnt <= '0;
          over <= 1'b0;
          dec <= 1'b0;
          rd_last <= !aw_go;
          state <= aw_go ? WDATA : RDATA;
        end
        WDATA: if (w_go) begin
          cnt <= cnt + 8'd1;
          a_addr <= a_fixed ? a_addr : a_addr + 32'd4;
          over <= over || cnt == a_len;
          dec <= dec || (!win && !over);
          if (AXI_DDR_wlast) begin
            state <= WRESP;
            AXI_DDR_bvalid <= 1'b1;
            AXI_DDR_bid <= a_id;
            AXI_DDR_bresp <= (a_bad || over || cnt != a_len) ? 2'b10 : (dec || !win) ? 2'b11 : 2'b00;
          end
        end
        WRESP: if (AXI_DDR_bready) begin
          AXI_DDR_bvalid <= 1'b0;
          state <= IDLE;
        end
        RDATA: if (AXI_DDR_rvalid && AXI_DDR_rready && AXI_DDR_rlast) begin
          AXI_DDR_rvalid <= 1'b0;
          AXI_DDR_rlast <= 1'b0;
          state <= IDLE;
        end else if (!AXI_DDR_rvalid || AXI_DDR_rready) begin
          AXI_DDR_rvalid <= 1'b1;
          AXI_DDR_rid <= a_id;
          AXI_DDR_rlast <= cnt == a_len;
          AXI_DDR_rresp <= a_bad ? 2'b10 : win ? 2'b00 : 2'b11;
          AXI_DDR_rdata <= (a_bad || !win) ? 32'd0 : mem[idx];
          cnt <= cnt + 8'd1;
          a_addr <= a_fixed ? a_addr : a_addr + 32'd4;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_ddr_slave_mem.sv
// tb_axi_ddr_slave_mem: scoreboard bench with a word-level reference memory
module tb_axi_ddr_slave_mem;
  localparam int MEM_AW = 14;
  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] AXI_DDR_awaddr = '0, AXI_DDR_araddr = '0, AXI_DDR_wdata = '0;
  logic [7:0] AXI_DDR_awlen = '0, AXI_DDR_arlen = '0;
  logic [2:0] AXI_DDR_awsize = 3'd2, AXI_DDR_arsize = 3'd2;
  logic [1:0] AXI_DDR_awburst = 2'b01, AXI_DDR_arburst = 2'b01;
  logic [3:0] AXI_DDR_awid = '0, AXI_DDR_arid = '0, AXI_DDR_wstrb = '0;
  logic AXI_DDR_awvalid = 1'b0, AXI_DDR_arvalid = 1'b0, AXI_DDR_wvalid = 1'b0, AXI_DDR_wlast = 1'b0;
  logic AXI_DDR_rready = 1'b1, AXI_DDR_bready = 1'b1;
  logic AXI_DDR_awready, AXI_DDR_arready, AXI_DDR_wready, AXI_DDR_rlast, AXI_DDR_rvalid;
  logic AXI_DDR_ruser, AXI_DDR_bvalid, AXI_DDR_buser;
  logic [31:0] AXI_DDR_rdata;
  logic [1:0] AXI_DDR_rresp, AXI_DDR_bresp;
  logic [3:0] AXI_DDR_rid, AXI_DDR_bid;

  axi_ddr_slave_mem #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .AXI_DDR_awaddr(AXI_DDR_awaddr), .AXI_DDR_awlen(AXI_DDR_awlen), .AXI_DDR_awsize(AXI_DDR_awsize),
    .AXI_DDR_awburst(AXI_DDR_awburst), .AXI_DDR_awid(AXI_DDR_awid), .AXI_DDR_awvalid(AXI_DDR_awvalid),
    .AXI_DDR_awready(AXI_DDR_awready), .AXI_DDR_awprot(3'd0), .AXI_DDR_awregion(4'd0),
    .AXI_DDR_awcache(4'd0), .AXI_DDR_awqos(4'd0), .AXI_DDR_awlock(1'b0), .AXI_DDR_awuser(1'b0),
    .AXI_DDR_araddr(AXI_DDR_araddr), .AXI_DDR_arlen(AXI_DDR_arlen), .AXI_DDR_arsize(AXI_DDR_arsize),
    .AXI_DDR_arburst(AXI_DDR_arburst), .AXI_DDR_arid(AXI_DDR_arid), .AXI_DDR_arvalid(AXI_DDR_arvalid),
    .AXI_DDR_arready(AXI_DDR_arready), .AXI_DDR_arprot(3'd0), .AXI_DDR_arregion(4'd0),
    .AXI_DDR_arcache(4'd0), .AXI_DDR_arqos(4'd0), .AXI_DDR_arlock(1'b0), .AXI_DDR_aruser(1'b0),
    .AXI_DDR_wdata(AXI_DDR_wdata), .AXI_DDR_wstrb(AXI_DDR_wstrb), .AXI_DDR_wlast(AXI_DDR_wlast),
    .AXI_DDR_wuser(4'd0), .AXI_DDR_wvalid(AXI_DDR_wvalid), .AXI_DDR_wready(AXI_DDR_wready),
    .AXI_DDR_rdata(AXI_DDR_rdata), .AXI_DDR_rresp(AXI_DDR_rresp), .AXI_DDR_rlast(AXI_DDR_rlast),
    .AXI_DDR_rid(AXI_DDR_rid), .AXI_DDR_rvalid(AXI_DDR_rvalid), .AXI_DDR_rready(AXI_DDR_rready),
    .AXI_DDR_ruser(AXI_DDR_ruser), .AXI_DDR_bresp(AXI_DDR_bresp), .AXI_DDR_bid(AXI_DDR_bid),
    .AXI_DDR_bvalid(AXI_DDR_bvalid), .AXI_DDR_bready(AXI_DDR_bready), .AXI_DDR_buser(AXI_DDR_buser)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] resp; logic [31:0] data; logic last; logic [3:0] id; bit known; } rexp_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];
  bit hs_log[$];
  logic [31:0] model [int];
  logic [31:0] dq[$];
  logic [3:0] sq[$];
  int checks = 0, failures = 0;
  int rr_mode = 0;
  bit b_rand = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >> (MEM_AW + 2)) == (BASE >> (MEM_AW + 2));
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [1:0] bu, input int i);
    return bu == 2'b00 ? a : a + 32'(4 * i);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[MEM_AW+1:2]);
  endfunction

  // Byte-merge into the reference; words never fully written stay unknown
  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input bit kill);
    int k;
    logic [31:0] w;
    k = widx(a);
    if (kill) model.delete(k);
    else if (s == 4'hF) model[k] = d;
    else if (model.exists(k)) begin
      w = model[k];
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      model[k] = w;
    end
  endtask

  task automatic push_read(input logic [31:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu,
                           input logic [3:0] id);
    rexp_t e;
    logic [31:0] ba;
    for (int i = 0; i <= len; i++) begin
      ba = baddr(a, bu, i);
      e.id = id;
      e.last = i == len;
      e.known = 1'b1;
      e.data = '0;
      if (sz != 3'd2 || bu[1]) e.resp = 2'b10;
      else if (!in_win(ba)) e.resp = 2'b11;
      else begin
        e.resp = 2'b00;
        e.known = model.exists(widx(ba));
        if (e.known) e.data = model[widx(ba)];
      end
      rq.push_back(e);
    end
  endtask

  task automatic fill(input int n, input bit full);
    dq.delete();
    sq.delete();
    for (int i = 0; i < n; i++) begin
      dq.push_back($urandom);
      sq.push_back((full || $urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom));
    end
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu,
                          input logic [3:0] id, input int nb, input logic [31:0] d[$], input logic [3:0] s[$]);
    bexp_t e;
    logic bad, dec;
    int t;
    bad = sz != 3'd2 || bu[1];
    dec = 1'b0;
    for (int i = 0; i <= len; i++) dec |= !in_win(baddr(a, bu, i));
    e.id = id;
    e.resp = (bad || nb - 1 != len) ? 2'b10 : dec ? 2'b11 : 2'b00;
    bq.push_back(e);
    AXI_DDR_awaddr = a;
    AXI_DDR_awlen = 8'(len);
    AXI_DDR_awsize = sz;
    AXI_DDR_awburst = bu;
    AXI_DDR_awid = id;
    AXI_DDR_awvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!AXI_DDR_awready && t < 500);
    chk("aw_accept", AXI_DDR_awready, 1);
    @(posedge clk); #1;
    AXI_DDR_awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      AXI_DDR_wdata = d[i];
      AXI_DDR_wstrb = s[i];
      AXI_DDR_wlast = i == nb - 1;
      AXI_DDR_wvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!AXI_DDR_wready && t < 50);
      chk("w_accept", AXI_DDR_wready, 1);
      @(posedge clk); #1;
      if (!bad && i <= len && in_win(baddr(a, bu, i))) model_wr(baddr(a, bu, i), d[i], s[i], nb - 1 < len);
    end
    AXI_DDR_wvalid = 1'b0;
    AXI_DDR_wlast = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!(AXI_DDR_bvalid && AXI_DDR_bready) && t < 100);
    chk("b_arrive", AXI_DDR_bvalid && AXI_DDR_bready, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu,
                         input logic [3:0] id);
    int t;
    AXI_DDR_araddr = a;
    AXI_DDR_arlen = 8'(len);
    AXI_DDR_arsize = sz;
    AXI_DDR_arburst = bu;
    AXI_DDR_arid = id;
    AXI_DDR_arvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!AXI_DDR_arready && t < 500);
    chk("ar_accept", AXI_DDR_arready, 1);
    push_read(a, len, sz, bu, id);
    @(posedge clk); #1;
    AXI_DDR_arvalid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!AXI_DDR_rvalid && t < 20);
    chk("r_latency", AXI_DDR_rvalid && t <= 2, 1);
    t = 0;
    while (!(AXI_DDR_rvalid && AXI_DDR_rready && AXI_DDR_rlast) && t < 600) begin @(negedge clk); t++; end
    chk("r_done", AXI_DDR_rvalid && AXI_DDR_rready && AXI_DDR_rlast, 1);
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    AXI_DDR_rready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? !AXI_DDR_rready : 1'($urandom_range(0, 1));
    AXI_DDR_bready = b_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops expectations on each B/R handshake and checks stall stability
  bexp_t be;
  rexp_t re;
  logic p_rstall = 1'b0, p_bstall = 1'b0;
  logic [38:0] p_r;
  logic [5:0] p_b;
  always @(negedge clk) begin
    if (rst) begin
      p_rstall = 1'b0;
      p_bstall = 1'b0;
    end else begin
      if (AXI_DDR_awvalid && AXI_DDR_awready) hs_log.push_back(1'b0);
      if (AXI_DDR_arvalid && AXI_DDR_arready) hs_log.push_back(1'b1);
      if (p_rstall)
        chk("r_stable", {AXI_DDR_rvalid, AXI_DDR_rdata, AXI_DDR_rresp, AXI_DDR_rlast, AXI_DDR_rid}, {1'b1, p_r});
      if (p_bstall) chk("b_stable", {AXI_DDR_bvalid, AXI_DDR_bresp, AXI_DDR_bid}, {1'b1, p_b});
      if (AXI_DDR_bvalid && AXI_DDR_bready) begin
        if (bq.size() == 0) chk("b_spurious", 1, 0);
        else begin
          be = bq.pop_front();
          chk("bresp", AXI_DDR_bresp, be.resp);
          chk("bid", AXI_DDR_bid, be.id);
        end
      end
      if (AXI_DDR_rvalid && AXI_DDR_rready) begin
        if (rq.size() == 0) chk("r_spurious", 1, 0);
        else begin
          re = rq.pop_front();
          chk("rresp", AXI_DDR_rresp, re.resp);
          chk("rlast", AXI_DDR_rlast, re.last);
          chk("rid", AXI_DDR_rid, re.id);
          if (re.known) chk("rdata", AXI_DDR_rdata, re.data);
        end
      end
      p_rstall = AXI_DDR_rvalid && !AXI_DDR_rready;
      p_r = {AXI_DDR_rdata, AXI_DDR_rresp, AXI_DDR_rlast, AXI_DDR_rid};
      p_bstall = AXI_DDR_bvalid && !AXI_DDR_bready;
      p_b = {AXI_DDR_bresp, AXI_DDR_bid};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 9))
      0: return BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 63) * 4);
      1: return BASE + 32'(4 * (DEPTH - 3));
      default: return BASE + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    logic [2:0] sz;
    logic [1:0] bu;
    int len, nb, r, t;
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {AXI_DDR_awready, AXI_DDR_arready, AXI_DDR_wready, AXI_DDR_bvalid, AXI_DDR_bresp,
        AXI_DDR_bid, AXI_DDR_rvalid, AXI_DDR_rdata, AXI_DDR_rresp, AXI_DDR_rlast, AXI_DDR_rid,
        AXI_DDR_ruser, AXI_DDR_buser}, 0);
    @(posedge clk); #1;
    for (int b = 0; b < 16; b++) begin
      fill(16, 1'b1);
      do_write(BASE + 32'(64 * b), 15, 3'd2, 2'b01, 4'(b), 16, dq, sq);
    end
    dq = {32'h11, 32'h22, 32'h33, 32'h44};
    sq = {4'hF, 4'hF, 4'hF, 4'hF};
    do_write(BASE + 32'h10, 3, 3'd2, 2'b01, 4'h5, 4, dq, sq);
    do_read(BASE + 32'h10, 3, 3'd2, 2'b01, 4'h6);
    dq = {32'h1122_3344};
    sq = {4'hF};
    do_write(BASE + 32'h80, 0, 3'd2, 2'b01, 4'h1, 1, dq, sq);
    dq = {32'hAABB_CCDD};
    sq = {4'b0101};
    do_write(BASE + 32'h80, 0, 3'd2, 2'b01, 4'h2, 1, dq, sq);
    do_read(BASE + 32'h80, 0, 3'd2, 2'b01, 4'h3);
    // Tie arbitration: reset points at write, then alternates with what was served last
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        fill(1, 1'b1);
        do_write(BASE + 32'h104, 0, 3'd2, 2'b01, 4'h9, 1, dq, sq);
      end
      fill(1, 1'b1);
      hs_log.delete();
      fork
        do_write(BASE + 32'h100, 0, 3'd2, 2'b01, 4'h7, 1, dq, sq);
        do_read(BASE + 32'h100, 0, 3'd2, 2'b01, 4'h8);
      join
      chk("grant_count", hs_log.size(), 2);
      if (hs_log.size() >= 2) chk("grant_order", {hs_log[0], hs_log[1]}, k == 2 ? 2'b10 : 2'b01);
    end
    rr_mode = 1;
    do_read(BASE + 32'h40, 7, 3'd2, 2'b01, 4'hA);
    rr_mode = 0;
    fill(1, 1'b1);
    do_write(BASE + 32'(4 * DEPTH), 0, 3'd2, 2'b01, 4'hB, 1, dq, sq);
    do_read(BASE, 0, 3'd2, 2'b01, 4'hB);
    do_write(BASE + 32'h30, 0, 3'd1, 2'b01, 4'hC, 1, dq, sq);
    do_read(BASE + 32'h30, 0, 3'd2, 2'b01, 4'hC);
    fill(3, 1'b1);
    do_write(BASE + 32'h300, 3, 3'd2, 2'b01, 4'hD, 3, dq, sq);
    do_read(BASE + 32'(4 * DEPTH), 1, 3'd2, 2'b01, 4'hE);
    do_read(BASE + 32'h20, 1, 3'd2, 2'b10, 4'hF);
    // Reset in the middle of a 4-beat write
    AXI_DDR_awaddr = BASE + 32'h200;
    AXI_DDR_awlen = 8'd3;
    AXI_DDR_awsize = 3'd2;
    AXI_DDR_awburst = 2'b01;
    AXI_DDR_awid = 4'h3;
    AXI_DDR_awvalid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!AXI_DDR_awready && t < 50);
    chk("rst_aw_accept", AXI_DDR_awready, 1);
    @(posedge clk); #1 AXI_DDR_awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      AXI_DDR_wdata = 32'hC0DE_0000 + 32'(i);
      AXI_DDR_wstrb = 4'hF;
      AXI_DDR_wvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!AXI_DDR_wready && t < 50);
      chk("rst_w_accept", AXI_DDR_wready, 1);
      @(posedge clk); #1;
      model_wr(BASE + 32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b0);
    end
    AXI_DDR_wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_midburst_outputs", {AXI_DDR_awready, AXI_DDR_arready, AXI_DDR_wready, AXI_DDR_bvalid,
        AXI_DDR_bresp, AXI_DDR_bid, AXI_DDR_rvalid, AXI_DDR_rdata, AXI_DDR_rresp, AXI_DDR_rlast,
        AXI_DDR_rid}, 0);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen |= AXI_DDR_bvalid; end
    chk("rst_no_bvalid", seen, 0);
    @(posedge clk); #1;
    do_read(BASE + 32'h200, 1, 3'd2, 2'b01, 4'h4);
    fill(4, 1'b1);
    do_write(BASE + 32'h200, 3, 3'd2, 2'b01, 4'h5, 4, dq, sq);
    for (int k = 0; k < 80; k++) begin
      a = rnd_addr();
      len = $urandom_range(0, 7);
      sz = $urandom_range(0, 9) == 0 ? 3'($urandom_range(0, 7)) : 3'd2;
      r = $urandom_range(0, 9);
      bu = r == 0 ? 2'b10 : r == 1 ? 2'b11 : r < 4 ? 2'b00 : 2'b01;
      rr_mode = $urandom_range(0, 2);
      b_rand = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 9);
        nb = r == 0 ? len + 2 : (r == 1 && len > 0) ? len : len + 1;
        fill(nb, 1'b0);
        do_write(a, len, sz, bu, 4'($urandom), nb, dq, sq);
      end else do_read(a, len, sz, bu, 4'($urandom));
    end
    rr_mode = 0;
    b_rand = 1'b0;
    repeat (5) @(negedge clk);
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_ddr_slave_mem.md
AXI_DDR_SLAVE_MEM -- requirements
Module: axi_ddr_slave_mem

Interface
REQ-001 MEM_AW, 14, log2 of memory depth in 32-bit words (64 KiB).
REQ-002 BASE_ADDR, 32'h0000_0000, byte base of window, aligned to 4*2^MEM_AW.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 AXI_DDR_awaddr  in  32  write burst start byte address.
REQ-006 AXI_DDR_awlen  in  8  write beats minus 1.
REQ-007 AXI_DDR_awsize  in  3  write beat size code.
REQ-008 AXI_DDR_awburst  in  2  write burst type.
REQ-009 AXI_DDR_awid  in  4  write transaction id.
REQ-010 AXI_DDR_awvalid  in  1  write address valid.
REQ-011 AXI_DDR_awready  out  1  write address accepted.
REQ-012 AXI_DDR_araddr / arlen / arsize / arburst / arid / arvalid  in  32/8/3/2/4/1  read equivalents of REQ-005..010.
REQ-013 AXI_DDR_arready  out  1  read address accepted.
REQ-014 AXI_DDR_{aw,ar}{prot,region,cache,qos,lock,user}, AXI_DDR_wuser  in  3/4/4/4/1/1, 4  accepted, ignored.
REQ-015 AXI_DDR_wdata  in  32  write data.
REQ-016 AXI_DDR_wstrb  in  4  byte enables.
REQ-017 AXI_DDR_wlast  in  1  last write beat.
REQ-018 AXI_DDR_wvalid  in  1 / AXI_DDR_wready  out  1  write data handshake.
REQ-019 AXI_DDR_rdata  out  32  read data.
REQ-020 AXI_DDR_rresp  out  2  per-beat read response.
REQ-021 AXI_DDR_rlast  out  1  last read beat.
REQ-022 AXI_DDR_rid  out  4  echoed arid.
REQ-023 AXI_DDR_rvalid  out  1 / AXI_DDR_rready  in  1  read data handshake.
REQ-024 AXI_DDR_bresp  out  2  write response; AXI_DDR_bid  out  4  echoed awid.
REQ-025 AXI_DDR_bvalid  out  1 / AXI_DDR_bready  in  1  write response handshake.
REQ-026 AXI_DDR_ruser, AXI_DDR_buser  out  1 each  constant 0.

Function
REQ-027 FSM states IDLE, WDATA, WRESP, RDATA; one transaction outstanding; single-port memory 2^MEM_AW x 32.
REQ-028 IDLE: awready/arready asserted only for the granted channel; both valid same cycle -> grant channel not served last (write first after reset); handshake latches addr, len, size, burst, id.
REQ-029 In-window iff addr[31:MEM_AW+2]==BASE_ADDR[31:MEM_AW+2]; word index addr[MEM_AW+1:2]; addr[1:0] ignored.
REQ-030 Beat address: FIXED holds; INCR +4 per beat, 32-bit wrap; window checked per beat.
REQ-031 AW handshake -> WDATA, wready=1; each W handshake at in-window, non-error beat writes bytes with wstrb set; write visible to next transaction.
REQ-032 W handshake with wlast -> WRESP; bvalid next cycle, bid=latched id, bvalid/bresp stable until bready; IDLE the cycle after B handshake.
REQ-033 bresp: SLVERR if awsize!=2, burst WRAP or 2'b11, or wlast beat index != awlen; else DECERR if any beat out of window; else OKAY.
REQ-034 SLVERR size/burst cases write nothing; DECERR beats dropped individually; beats beyond awlen before wlast accepted, not written.
REQ-035 AR handshake -> RDATA; first rvalid 1 or 2 cycles after handshake; next beat presented cycle after each R handshake (1 beat/cycle with rready=1).
REQ-036 rvalid=1 with rready=0: rvalid, rdata, rresp, rlast, rid held stable.
REQ-037 rresp per beat: SLVERR, rdata 0 for arsize!=2 or WRAP/reserved burst; DECERR, rdata 0 out of window; else OKAY with memory word; rlast only on beat arlen.
REQ-038 rlast handshake -> IDLE next cycle.

Reset
REQ-039 rst at clk edge: all outputs 0, FSM IDLE, grant pointer to write; mid-burst transaction abandoned, no response; memory not cleared, power-up content undefined.

Verification
REQ-040 Write INCR awlen=3 at BASE+0x10, data 11/22/33/44, wstrb F -> bresp 00, bid=awid; read same -> 11,22,33,44, rlast beat 4 only, rresp 00.
REQ-041 Word 0x11223344, write 0xAABBCCDD wstrb 0101 -> read 0x11BB33DD.
REQ-042 awvalid and arvalid together after reset -> AW served first, then AR; repeat -> alternates.
REQ-043 8-beat read, rready pattern 1010... -> 8 beats in order, none lost/duplicated, outputs stable when stalled.
REQ-044 Write at BASE+4*2^MEM_AW -> DECERR, memory unchanged; awsize=1 -> SLVERR, nothing written; wlast on beat 2 with awlen=3 -> SLVERR.
REQ-045 rst after 2 of 4 write beats -> outputs 0 next cycle, no bvalid; beats 0-1 retained; next transaction OKAY.
